// File: rtl/sobel_work_item_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_work_item_dispatcher_if
// Description : Issue-side handshake between the dispatcher and the first
//               basic block: offered work-item ids plus back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_work_item_dispatcher_if;
    logic        valid_out;
    logic        stall_in;
    logic [31:0] global_id;
    logic [31:0] local_id;
    logic [31:0] group_id;

    modport master (
        output valid_out,
        output global_id,
        output local_id,
        output group_id,
        input  stall_in
    );

    modport slave (
        input  valid_out,
        input  global_id,
        input  local_id,
        input  group_id,
        output stall_in
    );
endinterface
`default_nettype wire

// File: rtl/sobel_work_item_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : sobel_work_item_dispatcher
// Description : Launches a kernel, issues work-item ids under an in-flight
//               limit and pulses finish once every item has exited.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_work_item_dispatcher #(
    parameter int LIVE_W = 16
) (
    input  wire logic                  clock,
    input  wire logic                  resetn,
    input  wire logic                  start,
    input  wire logic [31:0]           global_size,
    input  wire logic [31:0]           workgroup_size,
    input  wire logic [LIVE_W-1:0]     max_live,
    sobel_work_item_dispatcher_if.master issue,
    input  wire logic                  exit_valid,
    output logic                       exit_stall,
    output logic                       busy,
    output logic                       finish,
    output logic [LIVE_W-1:0]          num_live
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LIVE_W-1:0] C_LIVE_ONE = {{(LIVE_W-1){1'b0}}, 1'b1};

    state_t            state_q,     state_d;
    logic [31:0]       gsize_q,     gsize_d;
    logic [31:0]       wgsize_q,    wgsize_d;
    logic [31:0]       gid_q,       gid_d;
    logic [31:0]       lid_q,       lid_d;
    logic [31:0]       grp_q,       grp_d;
    logic [31:0]       completed_q, completed_d;
    logic [LIVE_W-1:0] live_q,      live_d;

    logic w_offer;
    logic w_accept;
    logic w_exit;

    // The offer depends only on state and live count, and live can only rise
    // through an acceptance, so a pending offer is never withdrawn.
    assign w_offer  = (state_q == ISSUE) &&
                      ((max_live == '0) || (live_q < max_live));
    assign w_accept = w_offer && !issue.stall_in;
    assign w_exit   = exit_valid && ((state_q == ISSUE) || (state_q == DRAIN));

    always_comb begin
        state_d     = state_q;
        gsize_d     = gsize_q;
        wgsize_d    = wgsize_q;
        gid_d       = gid_q;
        lid_d       = lid_q;
        grp_d       = grp_q;
        completed_d = completed_q + {31'd0, w_exit};
        live_d      = live_q;

        if (w_accept && !w_exit) begin
            live_d = live_q + C_LIVE_ONE;
        end else if (w_exit && !w_accept) begin
            live_d = live_q - C_LIVE_ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    gsize_d     = global_size;
                    wgsize_d    = (workgroup_size == 32'd0) ? 32'd1 : workgroup_size;
                    gid_d       = 32'd0;
                    lid_d       = 32'd0;
                    grp_d       = 32'd0;
                    completed_d = 32'd0;
                    live_d      = '0;
                    state_d     = (global_size == 32'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_accept) begin
                    gid_d = gid_q + 32'd1;
                    if (lid_q == wgsize_q - 32'd1) begin
                        lid_d = 32'd0;
                        grp_d = grp_q + 32'd1;
                    end else begin
                        lid_d = lid_q + 32'd1;
                    end
                    if (gid_q == gsize_q - 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_exit && (completed_q + 32'd1 == gsize_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            gsize_q     <= 32'd0;
            wgsize_q    <= 32'd1;
            gid_q       <= 32'd0;
            lid_q       <= 32'd0;
            grp_q       <= 32'd0;
            completed_q <= 32'd0;
            live_q      <= '0;
        end else begin
            state_q     <= state_d;
            gsize_q     <= gsize_d;
            wgsize_q    <= wgsize_d;
            gid_q       <= gid_d;
            lid_q       <= lid_d;
            grp_q       <= grp_d;
            completed_q <= completed_d;
            live_q      <= live_d;
        end
    end

    assign issue.valid_out = w_offer;
    assign issue.global_id = gid_q;
    assign issue.local_id  = lid_q;
    assign issue.group_id  = grp_q;
    assign exit_stall      = 1'b0;
    assign busy            = (state_q != IDLE);
    assign finish          = (state_q == DONE);
    assign num_live        = live_q;

endmodule
`default_nettype wire
